// File: rtl/wave_capture.sv
// Captures 256-sample waveform snapshots into the half of a double-buffered RAM the display is not reading.
// Optional trigger timeout: define WAVE_CAPTURE_TIMEOUT_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_ARMED  | waiting for a positive zero crossing (or timeout)
// ST_ACTIVE | writing one converted sample per strobe, 256 in total
// ST_WAIT   | capture complete; waiting for display idle to swap halves
module wave_capture (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_sample_ready,
    input  logic [15:0] new_sample_in,
    input  logic        wave_display_idle,
    output logic [8:0]  write_address,
    output logic        write_enable,
    output logic [7:0]  write_sample,
    output logic        read_index
);

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic [15:0] prev_q, prev_d;
    logic        ri_q, ri_d;
    logic        we_q, we_d;
    logic [8:0]  addr_q, addr_d;
    logic [7:0]  ws_q, ws_d;
    logic        trigger;
    logic        timeout_hit;

    assign trigger = new_sample_ready && prev_q[15] && !new_sample_in[15];

`ifdef WAVE_CAPTURE_TIMEOUT_EN
    logic [9:0] armed_cnt_q, armed_cnt_d;

    assign timeout_hit = new_sample_ready && (state_q == ST_ARMED)
                         && (armed_cnt_q == 10'h3FF) && !trigger;

    always_comb begin
        armed_cnt_d = armed_cnt_q;
        if (state_q == ST_ARMED && new_sample_ready)
            armed_cnt_d = armed_cnt_q + 10'd1;
        // Fresh timeout window every time the FSM re-arms.
        if (state_q == ST_WAIT && state_d == ST_ARMED)
            armed_cnt_d = 10'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) armed_cnt_q <= 10'd0;
        else       armed_cnt_q <= armed_cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        prev_d  = new_sample_ready ? new_sample_in : prev_q;
        ri_d    = ri_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        ws_d    = ws_q;
        case (state_q)
            ST_ARMED: begin
                if (trigger || timeout_hit) begin
                    state_d = ST_ACTIVE;
                    count_d = 8'd0;
                end
            end
            ST_ACTIVE: begin
                if (new_sample_ready) begin
                    we_d    = 1'b1;
                    addr_d  = {~ri_q, count_q};
                    ws_d    = {~new_sample_in[15], new_sample_in[14:8]};
                    count_d = count_q + 8'd1;
                    if (count_q == 8'hFF)
                        state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wave_display_idle) begin
                    ri_d    = ~ri_q;
                    state_d = ST_ARMED;
                end
            end
            default: state_d = ST_ARMED;
        endcase
    end

    // Reset dominates a same-cycle strobe, so a pending write never escapes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ARMED;
            count_q <= 8'd0;
            prev_q  <= 16'd0;
            ri_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 9'd0;
            ws_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            prev_q  <= prev_d;
            ri_q    <= ri_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            ws_q    <= ws_d;
        end
    end

    assign write_address = addr_q;
    assign write_enable  = we_q;
    assign write_sample  = ws_q;
    assign read_index    = ri_q;

endmodule

// File: tb/tb_wave_capture.sv
// Scoreboard bench for wave_capture: stimulus pushes expected writes, a monitor pops and compares.
// Build with WAVE_CAPTURE_TIMEOUT_EN to also exercise the trigger timeout.
module tb_wave_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        new_sample_ready;
    logic [15:0] new_sample_in;
    logic        wave_display_idle;
    logic [8:0]  write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;

    wave_capture dut (
        .clk              (clk),
        .reset            (reset),
        .new_sample_ready (new_sample_ready),
        .new_sample_in    (new_sample_in),
        .wave_display_idle(wave_display_idle),
        .write_address    (write_address),
        .write_enable     (write_enable),
        .write_sample     (write_sample),
        .read_index       (read_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] a;
        logic [7:0] d;
        int         c;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   wr_seen = 0;
    int   exp_writes = 0;

    always @(posedge clk) cyc++;

    // Monitor: every write must match the oldest expected entry, including its cycle.
    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            exp_t e;
            wr_seen++;
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write addr=%h data=%h cyc=%0d", write_address, write_sample, cyc);
            end else begin
                e = exp_q.pop_front();
                if (write_address === e.a && write_sample === e.d && cyc == e.c
                    && write_address[8] === ~read_index)
                    pass_cnt++;
                else
                    $display("FAIL write actual addr=%h data=%h cyc=%0d ri=%b expected addr=%h data=%h cyc=%0d",
                             write_address, write_sample, cyc, read_index, e.a, e.d, e.c);
            end
        end
    end

    task automatic check(input string name, input int act, input int expv);
        total_cnt++;
        if (act == expv) pass_cnt++;
        else $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    endtask

    task automatic strobe(input logic [15:0] v, input bit w, input logic [8:0] a, input logic [7:0] d);
        @(negedge clk);
        new_sample_ready = 1'b1;
        new_sample_in    = v;
        if (w) begin
            exp_q.push_back('{a, d, cyc + 1});
            exp_writes++;
        end
        @(negedge clk);
        new_sample_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic settle(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_writes"}, wr_seen, exp_writes);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b1;
        new_sample_ready  = 1'b0;
        new_sample_in     = 16'd0;
        wave_display_idle = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_addr", int'(write_address), 0);
        check("rst_sample", int'(write_sample), 0);
        check("rst_we", int'(write_enable), 0);
        check("rst_ri", int'(read_index), 0);

        // Crossing capture into upper half, then strobes in WAIT
        strobe(-16'sd100, 0, 9'd0, 8'd0);
        strobe(16'sd50, 0, 9'd0, 8'd0);
        for (int k = 0; k < 256; k++)
            strobe(16'(k * 16), 1, 9'(256 + k), 8'(128 + k / 16));
        strobe(-16'sd7, 0, 9'd0, 8'd0);
        strobe(16'sd200, 0, 9'd0, 8'd0);
        strobe(-16'sd5, 0, 9'd0, 8'd0);
        settle("cap1");
        check("cap1_ri", int'(read_index), 0);

        // Handoff, then second capture into lower half with conversion corners
        @(negedge clk);
        wave_display_idle = 1'b1;
        @(negedge clk);
        wave_display_idle = 1'b0;
        check("handoff_ri", int'(read_index), 1);
        strobe(16'sd7, 0, 9'd0, 8'd0);
        strobe(16'h8000, 1, 9'd0, 8'h00);
        strobe(16'h7FFF, 1, 9'd1, 8'hFF);
        strobe(16'h0000, 1, 9'd2, 8'h80);
        for (int k = 3; k < 256; k++)
            strobe(16'(k << 8), 1, 9'(k), 8'(k) ^ 8'h80);
        settle("cap2");
        check("cap2_ri", int'(read_index), 1);

        // Strobe and idle together in WAIT: no write, swap, negative becomes prev
        @(negedge clk);
        new_sample_ready  = 1'b1;
        new_sample_in     = -16'sd300;
        wave_display_idle = 1'b1;
        @(negedge clk);
        new_sample_ready  = 1'b0;
        wave_display_idle = 1'b0;
        check("combo_ri", int'(read_index), 0);
        strobe(16'sd20, 0, 9'd0, 8'd0);
        for (int k = 0; k < 100; k++)
            strobe(16'h1234, 1, 9'(256 + k), 8'h92);

        // Reset in the cycle of a strobe after the 100th write
        @(negedge clk);
        new_sample_ready = 1'b1;
        new_sample_in    = 16'h1234;
        reset            = 1'b1;
        @(negedge clk);
        new_sample_ready = 1'b0;
        reset            = 1'b0;
        settle("rst_mid");
        check("rst_mid_ri", int'(read_index), 0);
        check("rst_mid_addr", int'(write_address), 0);

        // A negative sample before reset must not arm a crossing afterwards
        strobe(-16'sd5, 0, 9'd0, 8'd0);
        do_reset();
        strobe(16'sd5, 0, 9'd0, 8'd0);
        strobe(16'sd6, 0, 9'd0, 8'd0);
        strobe(-16'sd1, 0, 9'd0, 8'd0);
        strobe(16'sd1, 0, 9'd0, 8'd0);
        strobe(16'h8000, 1, 9'd256, 8'h00);
        strobe(16'h7FFF, 1, 9'd257, 8'hFF);
        do_reset();
        settle("restart");

        // No trigger on constant positive input; FSM still armed afterwards
        for (int k = 0; k < 300; k++)
            strobe(16'sd1000, 0, 9'd0, 8'd0);
        settle("notrig");
        strobe(-16'sd2, 0, 9'd0, 8'd0);
        strobe(16'sd2, 0, 9'd0, 8'd0);
        strobe(16'h0000, 1, 9'd256, 8'h80);
        do_reset();
        settle("still_armed");

`ifdef WAVE_CAPTURE_TIMEOUT_EN
        for (int k = 0; k < 1024; k++)
            strobe(16'hFFFF, 0, 9'd0, 8'd0);
        strobe(16'sd3, 1, 9'd256, 8'h80);
        strobe(16'h4000, 1, 9'd257, 8'hC0);
        do_reset();
        settle("timeout");
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 clk  input  1  system clock (100 MHz domain); all state updates on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 new_sample_ready  input  1  one-cycle strobe; new_sample_in is valid when this is high.
REQ-004 new_sample_in  input  16  signed two's-complement audio sample from the music player.
REQ-005 wave_display_idle  input  1  high while the display is not reading the capture RAM (vertical blanking).
REQ-006 write_address  output  9  RAM write address: {~read_index, sample_count[7:0]}.
REQ-007 write_enable  output  1  one-cycle RAM write strobe.
REQ-008 write_sample  output  8  offset-binary sample: {~s[15], s[14:8]}.
REQ-009 read_index  output  1  selects the half of the RAM that the display reads; the capture writes the other half.

Function
REQ-010 The block SHALL implement a three-state FSM: ARMED, ACTIVE, WAIT.
REQ-011 The block SHALL hold prev_sample, a 16-bit register.
- Loads new_sample_in on every new_sample_ready strobe, in every state.
REQ-012 ARMED -> ACTIVE SHALL occur on a strobe where prev_sample[15]==1 and new_sample_in[15]==0 (positive zero crossing).
- The triggering sample is not written.
- sample_count is cleared to 0.
REQ-013 In ACTIVE, each strobe SHALL cause the following on the next cycle:
- write_enable=1;
- write_address={~read_index, sample_count};
- write_sample=converted new_sample_in.
- sample_count then increments.
REQ-014 Write latency SHALL be exactly one cycle from strobe to write_enable; write_enable is never high for two consecutive cycles unless strobes are consecutive.
REQ-015 After the write at sample_count==255, the FSM SHALL enter WAIT (256 writes per capture); sample_count wraps to 0.
REQ-016 In WAIT, strobes SHALL produce no writes.
REQ-017 In WAIT, when wave_display_idle==1, read_index SHALL toggle and the FSM SHALL return to ARMED on the same edge.
REQ-018 wave_display_idle SHALL be ignored in ARMED and ACTIVE.
REQ-019 Simultaneous strobe and idle in WAIT SHALL leave the strobe unwritten, but prev_sample still updates.
REQ-020 read_index SHALL change only per REQ-017, so the display half never switches mid-capture.
REQ-021 write_address[8] SHALL equal ~read_index at every write.

Reset
REQ-022 On reset, all of the following SHALL hold on the next edge, regardless of the current state:
- state=ARMED;
- sample_count=0;
- prev_sample=0;
- read_index=0;
- write_enable=0;
- write_address=0;
- write_sample=0.
REQ-023 Reset during ACTIVE SHALL abandon the partial capture with no further writes.
- A pending one-cycle-delayed write is suppressed.
REQ-024 prev_sample=0 after reset SHALL prevent a trigger on the first post-reset sample.

Configuration
REQ-025 Macro WAVE_CAPTURE_TIMEOUT_EN SHALL control a trigger timeout.
- Defined: a 10-bit armed_count clears on entry to ARMED and increments per strobe in ARMED.
- Defined: on the 1024th strobe without a crossing, the FSM forces ARMED -> ACTIVE; that sample is not written and sample_count is cleared.
- Not defined: the FSM waits in ARMED indefinitely; no timeout logic is synthesized.

Verification
REQ-026 Crossing capture: strobes with samples -100 then +50, followed by 256 strobes of value k*16.
- Writes go to addresses 256..511 (read_index=0).
- write_sample of the first write = 8'h80.
- Then WAIT.
REQ-027 Handoff: in WAIT, assert wave_display_idle for 1 cycle.
- read_index goes to 1 and state goes to ARMED.
- The next capture writes addresses 0..255.
REQ-028 No trigger: 300 strobes of constant +1000.
- Zero writes, state stays ARMED.
- With WAVE_CAPTURE_TIMEOUT_EN defined, 1024 negative-only strobes force a capture (first write address 256).
REQ-029 Conversion: in ACTIVE, input 16'h8000 -> 8'h00; 16'h7FFF -> 8'hFF; 16'h0000 -> 8'h80.
REQ-030 Reset mid-capture: assert reset after the 100th write, including in the cycle of a strobe.
- No write_enable follows.
- read_index=0.
- The next crossing restarts at address 256.
REQ-031 Strobe + idle in WAIT in the same cycle: no write; read_index toggles; the strobe's value becomes prev_sample (verified by a following positive sample triggering if that value was negative).
